// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops, multi-cycle bit-serial shifts,
// valid/ready handshake on both sides with optional signed saturation.
module alu_seq #(
    parameter int          WIDTH   = 16,
    parameter int          SHAMT_W = 4,
    parameter int unsigned SAT     = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [2:0]         flags,
    output logic               busy
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_INC  = 3'b100;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   result_q;
    logic [2:0]         flags_q;
    logic [SHAMT_W-1:0] shiftCnt_q;
    logic [1:0]         shiftOp_q;
    logic               outValid_q;

    logic [WIDTH-1:0]   arith_d;
    logic [WIDTH-1:0]   aluResult_d;
    logic               aluV_d;
    logic               isShift_d;
    logic [WIDTH-1:0]   shiftStep_d;

    assign isShift_d = (op[2] == 1'b1) && (op[1:0] != 2'b00);

    // Overflow and saturation are decided from the operand sign, so the
    // saturated value is the extreme on the side of a.
    always_comb begin
        arith_d     = a + b;
        aluResult_d = '0;
        aluV_d      = 1'b0;
        case (op)
            OP_ADD: begin
                arith_d = a + b;
                aluV_d  = (a[WIDTH-1] == b[WIDTH-1]) && (arith_d[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                arith_d = a - b;
                aluV_d  = (a[WIDTH-1] != b[WIDTH-1]) && (arith_d[WIDTH-1] != a[WIDTH-1]);
            end
            OP_INC: begin
                arith_d = a + ONE;
                aluV_d  = !a[WIDTH-1] && arith_d[WIDTH-1];
            end
            default: arith_d = a + b;
        endcase
        case (op)
            OP_NAND: aluResult_d = ~(a & b);
            OP_XOR:  aluResult_d = a ^ b;
            default: aluResult_d = arith_d;
        endcase
        if (SAT != 0 && aluV_d) begin
            aluResult_d = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_comb begin
        case (shiftOp_q)
            2'b01:   shiftStep_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            2'b10:   shiftStep_d = {1'b0, result_q[WIDTH-1:1]};
            default: shiftStep_d = {result_q[WIDTH-2:0], 1'b0};
        endcase
    end

    // Flags are written only on the transition into DONE for a non-shift op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            result_q   <= '0;
            flags_q    <= 3'b000;
            shiftCnt_q <= '0;
            shiftOp_q  <= 2'b00;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shiftOp_q <= op[1:0];
                        if (isShift_d && shamt != '0) begin
                            state_q    <= SHIFT;
                            result_q   <= a;
                            shiftCnt_q <= shamt;
                        end else if (isShift_d) begin
                            state_q    <= DONE;
                            result_q   <= a;
                            outValid_q <= 1'b1;
                        end else begin
                            state_q    <= DONE;
                            result_q   <= aluResult_d;
                            flags_q    <= {aluResult_d == '0, aluV_d, aluResult_d[WIDTH-1]};
                            outValid_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    result_q   <= shiftStep_d;
                    shiftCnt_q <= shiftCnt_q - 1'b1;
                    if (shiftCnt_q == SHAMT_W'(1)) begin
                        state_q    <= DONE;
                        outValid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q    <= IDLE;
                        outValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = outValid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: one unsaturated and one saturating instance share
// stimulus; a negedge monitor checks latency, result and flags per transfer.
module tb_alu_seq;

    localparam int W = 16;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [2:0]    op       = 3'b000;
    logic [W-1:0]  a        = '0;
    logic [W-1:0]  b        = '0;
    logic [3:0]    shamt    = '0;

    logic          inReady0, inReady1, outValid0, outValid1, busy0, busy1;
    logic [W-1:0]  result0, result1;
    logic [2:0]    flags0, flags1;

    typedef struct {
        logic [W-1:0] res;
        logic [2:0]   flg;
        int           due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    bit   seen0 = 1'b0;
    bit   seen1 = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    alu_seq #(.WIDTH(W), .SHAMT_W(4), .SAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady0),
        .op(op), .a(a), .b(b), .shamt(shamt), .out_valid(outValid0),
        .out_ready(out_ready), .result(result0), .flags(flags0), .busy(busy0)
    );

    alu_seq #(.WIDTH(W), .SHAMT_W(4), .SAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady1),
        .op(op), .a(a), .b(b), .shamt(shamt), .out_valid(outValid1),
        .out_ready(out_ready), .result(result1), .flags(flags1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Latency is checked the first cycle out_valid is seen; data on the handshake.
    task automatic monitorStep(input int idx, input logic ov, input logic [W-1:0] res, input logic [2:0] flg);
        exp_t e;
        int   n;
        bit   seen;
        n    = (idx == 0) ? q0.size() : q1.size();
        seen = (idx == 0) ? seen0 : seen1;
        if (ov) begin
            if (n == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedValid dut%0d: got out_valid 1 with result 0x%0h, required no output", idx, res);
            end else begin
                e = (idx == 0) ? q0[0] : q1[0];
                if (!seen) begin
                    checkOutput($sformatf("latency dut%0d", idx), cyc, e.due);
                    seen = 1'b1;
                end
                if (out_ready) begin
                    checkOutput($sformatf("result dut%0d", idx), res, e.res);
                    checkOutput($sformatf("flags dut%0d", idx), flg, e.flg);
                    if (idx == 0) void'(q0.pop_front());
                    else void'(q1.pop_front());
                    seen = 1'b0;
                end
            end
        end
        if (idx == 0) seen0 = seen;
        else seen1 = seen;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            seen0 = 1'b0;
            seen1 = 1'b0;
        end else begin
            monitorStep(0, outValid0, result0, flags0);
            monitorStep(1, outValid1, result1, flags1);
        end
    end

    task automatic waitIdle();
        int waitCnt = 0;
        @(negedge clk);
        while (!inReady0 && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [3:0] sh, input logic [W-1:0] r0, input logic [2:0] f0,
                                 input logic [W-1:0] r1, input logic [2:0] f1, input int lat,
                                 input bit expectOut);
        exp_t e;
        waitIdle();
        if (!inReady0) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout: in_ready got 0, required 1");
        end else begin
            op       = o;
            a        = av;
            b        = bv;
            shamt    = sh;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (expectOut) begin
                e.due = cyc + lat - 1;
                e.res = r0;
                e.flg = f0;
                q0.push_back(e);
                e.res = r1;
                e.flg = f1;
                q1.push_back(e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int busyCnt;
        int drainCnt;

        #1;
        checkOutput("resetResult", result0, 16'h0000);
        checkOutput("resetFlags", flags0, 3'b000);
        checkOutput("resetValid", outValid0, 1'b0);
        checkOutput("resetInReady", inReady0, 1'b1);
        checkOutput("resetBusy", busy0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // op, a, b, shamt, SAT=0 result/flags, SAT=1 result/flags, latency
        applyStimulus(3'b000, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 3'b011, 16'h7FFF, 3'b010, 1, 1'b1);
        applyStimulus(3'b001, 16'h8000, 16'h0001, 4'd0, 16'h7FFF, 3'b010, 16'h8000, 3'b011, 1, 1'b1);
        applyStimulus(3'b001, 16'h7FFF, 16'hFFFF, 4'd0, 16'h8000, 3'b011, 16'h7FFF, 3'b010, 1, 1'b1);
        applyStimulus(3'b000, 16'h8000, 16'hFFFF, 4'd0, 16'h7FFF, 3'b010, 16'h8000, 3'b011, 1, 1'b1);
        applyStimulus(3'b100, 16'h7FFF, 16'h1234, 4'd0, 16'h8000, 3'b011, 16'h7FFF, 3'b010, 1, 1'b1);
        applyStimulus(3'b000, 16'h1234, 16'h1111, 4'd0, 16'h2345, 3'b000, 16'h2345, 3'b000, 1, 1'b1);
        applyStimulus(3'b001, 16'h0005, 16'h0005, 4'd0, 16'h0000, 3'b100, 16'h0000, 3'b100, 1, 1'b1);

        applyStimulus(3'b101, 16'h8000, 16'h1111, 4'd4, 16'hF800, 3'b100, 16'hF800, 3'b100, 5, 1'b1);
        busyCnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy0) busyCnt++;
            else break;
        end
        checkOutput("busyCycles", busyCnt, 5);

        applyStimulus(3'b010, 16'hFF00, 16'h0FF0, 4'd3, 16'hF0FF, 3'b001, 16'hF0FF, 3'b001, 1, 1'b1);
        applyStimulus(3'b110, 16'h8001, 16'h0000, 4'd1, 16'h4000, 3'b001, 16'h4000, 3'b001, 2, 1'b1);
        applyStimulus(3'b111, 16'h0003, 16'h0000, 4'd0, 16'h0003, 3'b001, 16'h0003, 3'b001, 1, 1'b1);

        // Consumer stalls three cycles while a competing request is held on the inputs.
        waitIdle();
        out_ready = 1'b0;
        applyStimulus(3'b011, 16'hFFFF, 16'h0F0F, 4'd0, 16'hF0F0, 3'b001, 16'hF0F0, 3'b001, 1, 1'b1);
        in_valid = 1'b1;
        op       = 3'b000;
        a        = 16'h0001;
        b        = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stallResult", result0, 16'hF0F0);
            checkOutput("stallFlags", flags0, 3'b001);
            checkOutput("stallInReady", inReady0, 1'b0);
            checkOutput("stallValid", outValid0, 1'b1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        applyStimulus(3'b101, 16'h8421, 16'h0000, 4'd15, 16'hFFFF, 3'b001, 16'hFFFF, 3'b001, 16, 1'b1);

        // Long shift aborted by reset; it must never produce an output.
        applyStimulus(3'b111, 16'h0001, 16'h0000, 4'd15, 16'h0000, 3'b000, 16'h0000, 3'b000, 16, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abortValid", outValid0, 1'b0);
        checkOutput("abortResult", result0, 16'h0000);
        checkOutput("abortFlags", flags0, 3'b000);
        checkOutput("abortBusy", busy0, 1'b0);
        checkOutput("abortInReady", inReady0, 1'b1);
        checkOutput("abortValidSat", outValid1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        applyStimulus(3'b100, 16'hFFFF, 16'h0000, 4'd0, 16'h0000, 3'b100, 16'h0000, 3'b100, 1, 1'b1);

        drainCnt = 0;
        while ((q0.size() != 0 || q1.size() != 0) && drainCnt < 50) begin
            @(negedge clk);
            drainCnt++;
        end
        checkOutput("drainQ0", q0.size(), 0);
        checkOutput("drainQ1", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; legal values 8..64.
REQ-002 Parameter SHAMT_W, default 4, shift-amount width; SHALL equal clog2(WIDTH).
REQ-003 Parameter SAT, default 0, when 1 ADD/SUB/INC saturate on signed overflow.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  operation request present.
REQ-007 in_ready  output  1  block accepts a request this cycle.
REQ-008 op  input  3  opcode: 000 ADD, 001 SUB, 010 NAND, 011 XOR, 100 INC, 101 SRA, 110 SRL, 111 SLL.
REQ-009 a  input  WIDTH  first operand, two's complement.
REQ-010 b  input  WIDTH  second operand, two's complement; ignored for INC and shifts.
REQ-011 shamt  input  SHAMT_W  unsigned shift amount; ignored for non-shift ops.
REQ-012 out_valid  output  1  result and flags valid.
REQ-013 out_ready  input  1  consumer takes result this cycle.
REQ-014 result  output  WIDTH  registered operation result.
REQ-015 flags  output  3  registered {Z,V,N}.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, SHIFT, DONE; in_ready SHALL be high only in IDLE.
REQ-018 Request accepted on rising edge with in_valid && in_ready; operands, op, shamt captured then; inputs ignored elsewhere.
REQ-019 Non-shift op, or shift with shamt=0: IDLE -> DONE at accept edge; out_valid high the cycle after accept.
REQ-020 Shift with shamt=n>0: IDLE -> SHIFT at accept, load counter n; one bit position shifted per cycle; counter decrements; SHIFT -> DONE on the edge where counter reaches 0; out_valid high exactly n+1 cycles after accept.
REQ-021 SRA fills with captured MSB; SRL and SLL fill with 0; final value identical to single-step shift by n.
REQ-022 ADD: a+b modulo 2^WIDTH; SUB: a-b; INC: a+1; NAND: ~(a&b); XOR: a^b.
REQ-023 V for ADD/INC SHALL be signed overflow: operands same sign, result sign differs; for SUB: operand signs differ and result sign differs from a.
REQ-024 With SAT=1 and V=1: positive overflow -> 2^(WIDTH-1)-1, negative overflow -> -2^(WIDTH-1); V still 1; Z,N computed on saturated value.
REQ-025 ADD/SUB/INC update Z,V,N; NAND/XOR update Z and N from result, clear V; shifts leave flags unchanged.
REQ-026 Flags register SHALL update only on the edge entering DONE; it holds across all other cycles and across operations.
REQ-027 In DONE, result and flags SHALL be stable until out_valid && out_ready; then DONE -> IDLE on that edge, out_valid low next cycle.
REQ-028 Minimum spacing between accepts: 2 cycles (accept, DONE with out_ready=1, accept again in IDLE).
REQ-029 in_valid high in SHIFT or DONE SHALL have no effect; no request buffering.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, out_valid 0, result 0, flags 3'b000, counter 0, busy 0; in_ready 1.
REQ-031 Reset during SHIFT or DONE SHALL discard the in-flight operation; no out_valid pulse for it after release.
REQ-032 First accept permitted on first rising edge with rst_n high.

Verification (WIDTH=16)
REQ-033 SAT=0, ADD a=0x7FFF b=0x0001, out_ready=1 -> out_valid 1 cycle after accept, result 0x8000, flags 3'b011.
REQ-034 SAT=1, same ADD -> result 0x7FFF, flags 3'b010; SUB a=0x8000 b=0x0001 -> 0x8000, flags 3'b011.
REQ-035 SUB a=0x0005 b=0x0005 -> result 0x0000, flags 3'b100; next SRA a=0x8000 shamt=4 -> result 0xF800 exactly 5 cycles after accept, flags still 3'b100, busy high 5 cycles.
REQ-036 XOR a=0xFFFF b=0x0F0F with out_ready low 3 cycles -> result 0xF0F0, flags 3'b001 stable, in_ready low, concurrent in_valid ignored; transfer on 4th cycle.
REQ-037 SLL a=0x0001 shamt=15, rst_n pulsed low at cycle 7 -> outputs at reset values immediately, no out_valid afterwards; new INC a=0xFFFF after release -> 0x0000, flags 3'b100.
